// File: rtl/keypad_key_capture.sv
// keypad_key_capture
//   Debounces a keypress reported by the upstream row scanner, decodes the row/col
//   pair to a hex key and shifts it into a two-digit display history. A one-cycle
//   key_valid strobe marks each accepted key. A new key is only accepted after the
//   previous one has been stably released.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable-press cycles before a key is accepted (>= 2)
//   RELEASE_CYCLES   consecutive all-cols-low cycles before re-arming (>= 2)
//
// Ports
//   clk        in   1  system clock
//   reset      in   1  synchronous, active-low reset
//   rows       in   4  one-hot row drive from the scanner, bit i = row i
//   cols       in   4  synchronized column sense, bit j = col j pressed
//   change     in   1  scanner strobe, high while a new press is reported
//   key_valid  out  1  one-cycle pulse, new key accepted
//   digit_new  out  4  most recently accepted key code
//   digit_old  out  4  previously accepted key code

module keypad_key_capture #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned RELEASE_CYCLES  = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   input  logic [3:0] cols,
   input  logic       change,
   output logic       key_valid,
   output logic [3:0] digit_new,
   output logic [3:0] digit_old
);

   localparam int unsigned MAX_CYCLES =
      (DEBOUNCE_CYCLES > RELEASE_CYCLES) ? DEBOUNCE_CYCLES : RELEASE_CYCLES;
   localparam int unsigned CNT_W = $clog2(MAX_CYCLES) + 1;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      StIdle,
      StDebounce,
      StHeld
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       row_q;
   logic [3:0]       col_q;

   // Exactly one bit set; rejects idle (all zero) and multi-key patterns.
   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

   logic arm;
   logic same_key;

   always_comb begin
      arm      = change && is_onehot(rows) && is_onehot(cols);
      same_key = (rows == row_q) && (cols == col_q);
   end

   // Decode the latched key. The latched pair equals the live inputs on the
   // accepting edge, so this is the code of the key being accepted.
   logic [1:0] row_idx;
   logic [1:0] col_idx;
   logic [3:0] key_code;

   always_comb begin
      row_idx = 2'd0;
      case (row_q)
         4'b0001: row_idx = 2'd0;
         4'b0010: row_idx = 2'd1;
         4'b0100: row_idx = 2'd2;
         4'b1000: row_idx = 2'd3;
         default: row_idx = 2'd0;
      endcase
      col_idx = 2'd0;
      case (col_q)
         4'b0001: col_idx = 2'd0;
         4'b0010: col_idx = 2'd1;
         4'b0100: col_idx = 2'd2;
         4'b1000: col_idx = 2'd3;
         default: col_idx = 2'd0;
      endcase
   end

   always_comb begin
      key_code = 4'h0;
      case ({row_idx, col_idx})
         4'b00_00: key_code = 4'h1;
         4'b00_01: key_code = 4'h2;
         4'b00_10: key_code = 4'h3;
         4'b00_11: key_code = 4'hA;
         4'b01_00: key_code = 4'h4;
         4'b01_01: key_code = 4'h5;
         4'b01_10: key_code = 4'h6;
         4'b01_11: key_code = 4'hB;
         4'b10_00: key_code = 4'h7;
         4'b10_01: key_code = 4'h8;
         4'b10_10: key_code = 4'h9;
         4'b10_11: key_code = 4'hC;
         4'b11_00: key_code = 4'hE;
         4'b11_01: key_code = 4'h0;
         4'b11_10: key_code = 4'hF;
         4'b11_11: key_code = 4'hD;
         default:  key_code = 4'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         row_q     <= 4'b0000;
         col_q     <= 4'b0000;
         key_valid <= 1'b0;
         digit_new <= 4'h0;
         digit_old <= 4'h0;
      end else begin
         key_valid <= 1'b0;
         case (state_q)
            StIdle: begin
               if (arm) begin
                  row_q   <= rows;
                  col_q   <= cols;
                  cnt_q   <= CNT_ONE;
                  state_q <= StDebounce;
               end
            end

            StDebounce: begin
               if (!same_key) begin
                  // Bounce, including on the accepting edge: drop the press.
                  cnt_q   <= '0;
                  state_q <= StIdle;
               end else if (cnt_q >= DEB_LAST) begin
                  digit_old <= digit_new;
                  digit_new <= key_code;
                  key_valid <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= StHeld;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end

            StHeld: begin
               // change is ignored here; only a run of quiet cols re-arms.
               if (cols != 4'b0000) begin
                  cnt_q <= '0;
               end else if (cnt_q >= REL_LAST) begin
                  cnt_q   <= '0;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end

            default: begin
               cnt_q   <= '0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_key_capture.sv
// Directed bench for keypad_key_capture with DEBOUNCE_CYCLES=4, RELEASE_CYCLES=3.
// Each vector drives inputs sampled at one rising edge and lists the outputs
// expected just after that edge.

module tb_keypad_key_capture;

   localparam int unsigned DEB = 4;
   localparam int unsigned REL = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] rows;
   logic [3:0] cols;
   logic       change;
   logic       key_valid;
   logic [3:0] digit_new;
   logic [3:0] digit_old;

   keypad_key_capture #(
      .DEBOUNCE_CYCLES (DEB),
      .RELEASE_CYCLES  (REL)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rows      (rows),
      .cols      (cols),
      .change    (change),
      .key_valid (key_valid),
      .digit_new (digit_new),
      .digit_old (digit_old)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] r;
      logic [3:0] c;
      logic       ch;
      logic       kv;
      logic [3:0] dn;
      logic [3:0] dold;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Key map straight from the keypad legend, index row*4+col.
   logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};
   logic [3:0] m_new;
   logic [3:0] m_old;

   task automatic add(input logic rst, input logic [3:0] r, input logic [3:0] c,
                      input logic ch, input logic kv, input logic [3:0] dn,
                      input logic [3:0] dold);
      vec_t v;
      v.rst = rst; v.r = r; v.c = c; v.ch = ch;
      v.kv = kv; v.dn = dn; v.dold = dold;
      vecs.push_back(v);
   endtask

   task automatic apply(input logic rst, input logic [3:0] r, input logic [3:0] c,
                        input logic ch);
      reset  = rst;
      rows   = r;
      cols   = c;
      change = ch;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic kv, input logic [3:0] dn,
                        input logic [3:0] dold);
      n_vec++;
      if (key_valid !== kv || digit_new !== dn || digit_old !== dold) begin
         n_err++;
         $display("FAIL %s: got key_valid=%b digit_new=%h digit_old=%h, want %b %h %h",
                  name, key_valid, digit_new, digit_old, kv, dn, dold);
      end
   endtask

   // Release with the scanner still driving the row: REL quiet cycles.
   task automatic release_key(input logic [3:0] r);
      for (int k = 0; k < int'(REL); k++) begin
         apply(1'b1, r, 4'b0000, 1'b0);
         check("release", 1'b0, m_new, m_old);
      end
   endtask

   task automatic press_key(input int ri, input int ci);
      logic [3:0] r;
      logic [3:0] c;
      r = 4'b0001 << ri;
      c = 4'b0001 << ci;
      apply(1'b1, r, c, 1'b1);
      check($sformatf("arm r%0d c%0d", ri, ci), 1'b0, m_new, m_old);
      for (int k = 1; k < int'(DEB) - 1; k++) begin
         apply(1'b1, r, c, 1'b0);
         check($sformatf("debounce r%0d c%0d", ri, ci), 1'b0, m_new, m_old);
      end
      m_old = m_new;
      m_new = keymap[ri*4 + ci];
      apply(1'b1, r, c, 1'b0);
      check($sformatf("accept r%0d c%0d", ri, ci), 1'b1, m_new, m_old);
      apply(1'b1, r, c, 1'b0);
      check($sformatf("pulse end r%0d c%0d", ri, ci), 1'b0, m_new, m_old);
   endtask

   initial begin
      reset  = 1'b0;
      rows   = 4'b0000;
      cols   = 4'b0010;
      change = 1'b0;

      // Reset held two cycles with a column asserted.
      add(0, 4'h0, 4'h2, 0, 0, 4'h0, 4'h0);
      add(0, 4'h0, 4'h2, 0, 0, 4'h0, 4'h0);
      add(1, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0);
      // Key 5: strobe, then held; pulse DEB-1 edges after the strobe edge.
      add(1, 4'h2, 4'h2, 1, 0, 4'h0, 4'h0);
      add(1, 4'h2, 4'h2, 0, 0, 4'h0, 4'h0);
      add(1, 4'h2, 4'h2, 0, 0, 4'h0, 4'h0);
      add(1, 4'h2, 4'h2, 0, 1, 4'h5, 4'h0);
      for (int k = 0; k < 7; k++) add(1, 4'h2, 4'h2, 0, 0, 4'h5, 4'h0);
      for (int k = 0; k < 3; k++) add(1, 4'h2, 4'h0, 0, 0, 4'h5, 4'h0);
      // Key F.
      add(1, 4'h8, 4'h4, 1, 0, 4'h5, 4'h0);
      add(1, 4'h8, 4'h4, 0, 0, 4'h5, 4'h0);
      add(1, 4'h8, 4'h4, 0, 0, 4'h5, 4'h0);
      add(1, 4'h8, 4'h4, 0, 1, 4'hF, 4'h5);
      add(1, 4'h8, 4'h4, 0, 0, 4'hF, 4'h5);
      // Release glitch 0,0,1,0,0 with a strobe on the glitch, then a new press
      // while still held: the restarted count must keep it blocked.
      add(1, 4'h8, 4'h0, 0, 0, 4'hF, 4'h5);
      add(1, 4'h8, 4'h0, 0, 0, 4'hF, 4'h5);
      add(1, 4'h8, 4'h4, 1, 0, 4'hF, 4'h5);
      add(1, 4'h8, 4'h0, 0, 0, 4'hF, 4'h5);
      add(1, 4'h8, 4'h0, 0, 0, 4'hF, 4'h5);
      add(1, 4'h1, 4'h1, 1, 0, 4'hF, 4'h5);
      for (int k = 0; k < 3; k++) add(1, 4'h1, 4'h1, 0, 0, 4'hF, 4'h5);
      for (int k = 0; k < 3; k++) add(1, 4'h1, 4'h0, 0, 0, 4'hF, 4'h5);
      // Key 1 bouncing on the accepting edge.
      add(1, 4'h1, 4'h1, 1, 0, 4'hF, 4'h5);
      add(1, 4'h1, 4'h1, 0, 0, 4'hF, 4'h5);
      add(1, 4'h1, 4'h1, 0, 0, 4'hF, 4'h5);
      add(1, 4'h1, 4'h0, 0, 0, 4'hF, 4'h5);
      for (int k = 0; k < 3; k++) add(1, 4'h1, 4'h1, 0, 0, 4'hF, 4'h5);
      // Multi-key cols, then non-one-hot rows, with change held high.
      for (int k = 0; k < 5; k++) add(1, 4'h1, 4'h3, 1, 0, 4'hF, 4'h5);
      for (int k = 0; k < 4; k++) add(1, 4'h3, 4'h1, 1, 0, 4'hF, 4'h5);
      // Reset mid-debounce on key C.
      add(1, 4'h4, 4'h8, 1, 0, 4'hF, 4'h5);
      add(1, 4'h4, 4'h8, 0, 0, 4'hF, 4'h5);
      add(0, 4'h4, 4'h8, 0, 0, 4'h0, 4'h0);
      for (int k = 0; k < 4; k++) add(1, 4'h4, 4'h8, 0, 0, 4'h0, 4'h0);
      // Key C accepted cleanly after reset.
      add(1, 4'h4, 4'h8, 1, 0, 4'h0, 4'h0);
      add(1, 4'h4, 4'h8, 0, 0, 4'h0, 4'h0);
      add(1, 4'h4, 4'h8, 0, 0, 4'h0, 4'h0);
      add(1, 4'h4, 4'h8, 0, 1, 4'hC, 4'h0);
      add(1, 4'h4, 4'h8, 0, 0, 4'hC, 4'h0);

      foreach (vecs[i]) begin
         apply(vecs[i].rst, vecs[i].r, vecs[i].c, vecs[i].ch);
         check($sformatf("vec%0d", i), vecs[i].kv, vecs[i].dn, vecs[i].dold);
      end

      // Every key position through the history shift.
      m_new = 4'hC;
      m_old = 4'h0;
      release_key(4'b0100);
      for (int ri = 0; ri < 4; ri++) begin
         for (int ci = 0; ci < 4; ci++) begin
            press_key(ri, ci);
            release_key(4'b0001 << ri);
         end
      end

      // Reset while HELD returns straight to IDLE with cleared digits.
      press_key(2, 2);
      apply(1'b0, 4'b0100, 4'b0100, 1'b0);
      m_new = 4'h0;
      m_old = 4'h0;
      check("reset in held", 1'b0, m_new, m_old);
      press_key(1, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
